// File: rtl/rv32e_bus_pkg.sv
// Shared types and constants for the RV32E data-port memory fabric.
// Holds the access FSM states and fabric-wide defaults.
package rv32e_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
    localparam int          MAX_SLAVES   = 8;

    // Counter width able to hold 0..t; never narrower than one bit.
    function automatic int cnt_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/rv32e_addr_decode.sv
// Combinational region decoder: one-hot select of the lowest matching slave.
// hit_o is low when no region matches the address.
module rv32e_addr_decode #(
    parameter int                             NUM_SLAVES = 4,
    parameter int                             ADDR_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_BASE   = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_MASK   = '0
) (
    input  logic [ADDR_W-1:0]     addr_i,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic                  hit_o
);

    // Scan downwards so the lowest matching index is the last to overwrite.
    always_comb begin
        sel_o = '0;
        hit_o = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                sel_o    = '0;
                sel_o[i] = 1'b1;
                hit_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv32e_mem_fabric.sv
// Single-master, N-slave data-port interconnect with wait states,
// unmapped-address errors and a per-access timeout.
module rv32e_mem_fabric
    import rv32e_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
        {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
    parameter int TIMEOUT = 15,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         m_req,
    input  logic                         m_we,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_wstrb,
    output logic                         m_ready,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_err,
    output logic [NUM_SLAVES-1:0]        s_req,
    output logic                         s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam int SW = DATA_W / 8;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0]   sreq_q, sreq_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [SW-1:0]           wstrb_q, wstrb_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    dec_hit;
    logic                    sel_ready;
    logic [DATA_W-1:0]       sel_rdata;
    logic                    tmo;

    rv32e_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_dec (
        .addr_i (m_addr),
        .sel_o  (dec_sel),
        .hit_o  (dec_hit)
    );

    // Only the selected slave's ready and data are observed.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sreq_q[i]) begin
                sel_ready = sel_ready | s_ready[i];
                sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign tmo = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreq_d  = sreq_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (m_req) begin
                    we_d    = m_we;
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    wstrb_d = m_we ? m_wstrb : '0;
                    cnt_d   = '0;
                    if (dec_hit) begin
                        sreq_d  = dec_sel;
                        state_d = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (sel_ready) begin
                    rdata_d = we_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                    sreq_d  = '0;
                    state_d = RESP;
                end else if (tmo) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    sreq_d  = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreq_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreq_q  <= sreq_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign m_ready = (state_q == RESP);
    assign m_rdata = m_ready ? rdata_q : '0;
    assign m_err   = m_ready & err_q;
    assign s_req   = sreq_q;
    assign s_we    = we_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign s_wstrb = wstrb_q;

endmodule

// File: tb/tb_rv32e_mem_fabric.sv
// Scoreboard bench for rv32e_mem_fabric: directed cases plus random traffic
// against a decode/latency reference model and wait-state slave models.
module tb_rv32e_mem_fabric;

    localparam logic [31:0] BASE [4] = '{32'h0000_0000, 32'h2000_0000,
                                         32'h4000_0000, 32'h2000_0000};
    localparam logic [31:0] MASK [4] = '{32'hFFFF_0000, 32'hF000_0000,
                                         32'hFFFF_0000, 32'hFF00_0000};
    localparam int TMO = 15;

    typedef struct {
        int          sel;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        bit          err;
        int          lat;
        int          scyc;
        int          t0;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         m_req = 1'b0;
    logic         m_we = 1'b0;
    logic [31:0]  m_addr = '0;
    logic [31:0]  m_wdata = '0;
    logic [3:0]   m_wstrb = '0;
    logic         m_ready;
    logic [31:0]  m_rdata;
    logic         m_err;
    logic [3:0]   s_req;
    logic         s_we;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [3:0]   s_ready = '0;
    logic [127:0] s_rdata;

    logic [31:0]  sdata [4] = '{default: '0};
    int           wt [4] = '{default: 0};
    int           scnt [4] = '{default: 0};
    int           cyc = 0;
    int           vec = 0;
    int           bad = 0;
    bit           mon_en = 1'b0;
    exp_t         q[$];

    rv32e_mem_fabric #(
        .NUM_SLAVES (4),
        .ADDR_W     (32),
        .DATA_W     (32),
        .SLV_BASE   ({BASE[3], BASE[2], BASE[1], BASE[0]}),
        .SLV_MASK   ({MASK[3], MASK[2], MASK[1], MASK[0]}),
        .TIMEOUT    (TMO),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .m_err   (m_err),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_ready (s_ready),
        .s_rdata (s_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign s_rdata = {sdata[3], sdata[2], sdata[1], sdata[0]};

    // Slave i answers after wt[i] wait cycles of seeing its request.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (s_req[i]) begin
                if (scnt[i] >= wt[i]) begin
                    s_ready[i] <= 1'b1;
                end else begin
                    s_ready[i] <= 1'b0;
                    scnt[i]    <= scnt[i] + 1;
                end
            end else begin
                s_ready[i] <= 1'b0;
                scnt[i]    <= 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a & MASK[i]) == BASE[i]) return i;
        end
        return -1;
    endfunction

    // Monitor: slave-side attributes on request rise, master response on m_ready.
    initial begin
        logic [3:0] prev;
        int         sc;
        exp_t       e;
        prev = '0;
        sc   = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || reset) begin
                prev = '0;
                sc   = 0;
            end else begin
                if (s_req != '0) sc++;
                if (s_req != '0 && prev == '0) begin
                    if (q.size() == 0 || q[0].sel < 0) begin
                        chk("unexpected_sreq", {28'h0, s_req}, 32'h0);
                    end else begin
                        e = q[0];
                        chk("sreq_onehot", {28'h0, s_req}, 32'h1 << e.sel);
                        chk("s_addr", s_addr, e.addr);
                        chk("s_we", {31'h0, s_we}, {31'h0, e.we});
                        chk("s_wdata", s_wdata, e.wdata);
                        chk("s_wstrb", {28'h0, s_wstrb},
                            e.we ? {28'h0, e.wstrb} : 32'h0);
                    end
                end
                prev = s_req;
                if (m_ready) begin
                    if (q.size() == 0) begin
                        chk("spurious_ready", 32'h1, 32'h0);
                    end else begin
                        e = q.pop_front();
                        chk("m_rdata", m_rdata, e.rdata);
                        chk("m_err", {31'h0, m_err}, {31'h0, e.err});
                        chk("latency", cyc - e.t0, e.lat);
                        chk("sreq_cycles", sc, e.scyc);
                    end
                    sc = 0;
                end
            end
        end
    end

    task automatic issue(input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input int waits);
        exp_t e;
        bit   done;
        @(negedge clk);
        e.sel   = decode(a);
        e.we    = we;
        e.addr  = a;
        e.wdata = wd;
        e.wstrb = ws;
        if (e.sel >= 0) begin
            wt[e.sel]    = waits;
            sdata[e.sel] = $urandom;
        end
        if (e.sel < 0) begin
            e.err = 1'b1; e.rdata = 32'hDEAD_BEEF; e.lat = 1; e.scyc = 0;
        end else if (waits <= TMO) begin
            e.err   = 1'b0;
            e.rdata = we ? 32'h0 : sdata[e.sel];
            e.lat   = 2 + waits;
            e.scyc  = waits + 1;
        end else begin
            e.err = 1'b1; e.rdata = 32'hDEAD_BEEF;
            e.lat = TMO + 2; e.scyc = TMO + 1;
        end
        e.t0 = cyc;
        q.push_back(e);
        m_req = 1'b1; m_we = we; m_addr = a; m_wdata = wd; m_wstrb = ws;
        done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) begin
                m_we = ~we; m_addr = $urandom;
                m_wdata = $urandom; m_wstrb = 4'($urandom);
            end
            if (m_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            chk("ready_timeout", 32'h0, 32'h1);
            void'(q.pop_front());
        end
        m_req = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          k, r, w;
        repeat (2) @(negedge clk);
        chk("rst_sreq", {28'h0, s_req}, 32'h0);
        chk("rst_ready_err", {30'h0, m_ready, m_err}, 32'h0);
        chk("rst_rdata", m_rdata, 32'h0);
        chk("rst_s_bus", s_addr | s_wdata | {27'h0, s_wstrb, s_we}, 32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;

        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0);
        issue(1'b1, 32'h4000_0004, 32'h0000_00A5, 4'b0001, 3);
        issue(1'b0, 32'h9000_0000, 32'h0, 4'h0, 0);
        issue(1'b0, 32'h4000_0100, 32'h0, 4'h0, 1000);
        issue(1'b1, 32'h0000_0020, 32'h1111_2222, 4'hF, 1000);
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, TMO);
        issue(1'b0, 32'h0000_0044, 32'h0, 4'h0, TMO - 1);
        issue(1'b0, 32'h2000_0000, 32'h0, 4'h0, 1);
        issue(1'b1, 32'h2000_0008, 32'hCAFE_F00D, 4'b1010, 0);

        // Reset two cycles into a waited access.
        @(negedge clk);
        mon_en = 1'b0;
        wt[2]  = 10;
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h4000_0008;
        repeat (3) @(negedge clk);
        chk("pre_rst_sreq", {28'h0, s_req}, 32'h4);
        reset = 1'b1;
        #1;
        chk("async_rst_sreq", {28'h0, s_req}, 32'h0);
        chk("async_rst_ready", {31'h0, m_ready}, 32'h0);
        m_req = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        issue(1'b0, 32'h4000_000C, 32'h0, 4'h0, 2);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 4);
            case (k)
                0: a = {16'h0000, 16'($urandom)};
                1: a = {8'h21, 24'($urandom)};
                2: a = {16'h4000, 16'($urandom)};
                3: a = {8'h20, 24'($urandom)};
                default: a = {4'h9, 28'($urandom)};
            endcase
            r = $urandom_range(0, 9);
            if (r < 7)       w = $urandom_range(0, 4);
            else if (r == 7) w = TMO;
            else if (r == 8) w = TMO - 1;
            else             w = 200;
            issue(1'($urandom), a, $urandom, 4'($urandom), w);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
